hex_display_controller: RTL and testbench

Multi-digit, registered seven-segment display controller for the board's HEX displays. It captures a packed hex value on a load handshake and decodes it into per-digit segment registers, one digit per clock. It supports optional leading-zero blanking, per-digit blinking and configurable segment polarity. It sits between datapath/status logic and the HEX pins, and replaces per-digit combinational decoders.

---
 rtl/hex_display_controller.sv | 139 +++++++++++++
 tb/tb_hex_display_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_controller.sv
// Registered multi-digit seven-segment controller: captures a packed hex value,
// decodes one digit per clock, then applies blink gating and output polarity.
module hex_display_controller #(
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  ready,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(BLINK_DIV);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] WRAP = CW'(BLINK_DIV - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [4*DIGITS-1:0]  val_q;
  logic                 blz_q;
  logic [7*DIGITS-1:0]  seg_q;
  logic [CW-1:0]        blink_cnt;
  logic                 phase;

  logic [3:0]           cur_nib;
  logic                 cur_blank;
  logic [6:0]           dec;
  logic [6:0]           lit;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = val_q[4*i +: 4];
        cur_blank = blz_q && (i != 0) && ((val_q >> (4*i)) == '0);
      end
    end
    dec = cur_blank ? '0 : decode(cur_nib);
  end

  // A load held on the final write edge is taken immediately so back-to-back
  // updates run without an idle cycle between them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ready <= 1'b1;
      idx   <= '0;
      val_q <= '0;
      blz_q <= 1'b0;
      seg_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            val_q <= value;
            blz_q <= blank_lz;
            idx   <= '0;
            state <= UPDATE;
            ready <= 1'b0;
          end
        end
        UPDATE: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) seg_q[7*i +: 7] <= dec;
          end
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            if (load) begin
              val_q <= value;
              blz_q <= blank_lz;
              idx   <= '0;
            end else begin
              state <= IDLE;
              ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == WRAP) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    segments = '0;
    lit      = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      lit = seg_q[7*i +: 7];
      if (blink_en && blink_mask[i] && phase) lit = '0;
      segments[7*i +: 7] = (ACTIVE_LOW != 0) ? ~lit : lit;
    end
  end

endmodule

// File: tb/tb_hex_display_controller.sv
// Bench for hex_display_controller: directed scenarios plus randomized traffic
// checked every cycle against a load-schedule reference model.
module tb_hex_display_controller;

  localparam int D  = 6;
  localparam int BD = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic          blink_en = 1'b0;
  logic [23:0]   value = '0;
  logic [5:0]    blink_mask = '0;
  logic          ready;
  logic [41:0]   segments;

  always #5 clock = ~clock;

  hex_display_controller #(
    .DIGITS(D),
    .ACTIVE_LOW(1),
    .BLINK_DIV(BD)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .value(value),
    .load(load),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .blink_mask(blink_mask),
    .ready(ready),
    .segments(segments)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] inv7(input logic [6:0] x);
    return ~x;
  endfunction

  // Reference glyphs, gfedcba active-high
  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] glyph(input logic [23:0] v, input logic blz, input int i);
    logic [23:0] up;
    up = v >> (4 * i);
    if (blz && i > 0 && up == 24'd0) return 7'd0;
    return lut[up[3:0]];
  endfunction

  // Model: edges since reset; a load accepted at edge acc lands digit i at acc+i+1.
  logic [6:0] img [D];
  logic [6:0] tgt [D];
  int edges = 0;
  int acc = 0;
  bit job = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edges <= 0;
      acc   <= 0;
      job   <= 1'b0;
      for (int i = 0; i < D; i++) img[i] <= 7'd0;
    end else begin
      edges <= edges + 1;
      if (job && (edges - acc) < D) img[edges - acc] <= tgt[edges - acc];
      if (load && !(job && (edges - acc) < D - 1)) begin
        acc <= edges + 1;
        job <= 1'b1;
        for (int i = 0; i < D; i++) tgt[i] <= glyph(value, blank_lz, i);
      end
    end
  end

  function automatic logic [41:0] exp_seg();
    logic [41:0] r;
    logic [6:0]  l;
    bit          ph;
    ph = ((edges / BD) % 2) == 1;
    r = '0;
    for (int i = 0; i < D; i++) begin
      l = (blink_en && blink_mask[i] && ph) ? 7'd0 : img[i];
      r[7*i +: 7] = ~l;
    end
    return r;
  endfunction

  function automatic logic exp_ready();
    return !(job && (edges - acc) < D);
  endfunction

  bit mon = 1'b0;
  always @(negedge clock) begin
    if (mon) begin
      check("seg_model", 64'(segments), 64'(exp_seg()));
      check("ready_model", 64'(ready), 64'(exp_ready()));
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [23:0] v, input logic blz);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      cycle();
      n++;
    end
    check("ready_wait", 64'(ready), 64'(1));
    value    = v;
    blank_lz = blz;
    load     = 1'b1;
    cycle();
    load     = 1'b0;
  endtask

  logic [6:0] dec_exp [D] = '{7'h3F, 7'h71, 7'h4F, 7'h77, 7'h3F, 7'h3F};

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low;
    int cnt0;
    int bad;
    int n;

    repeat (2) @(posedge clock);
    #1;
    check("rst_seg_hold", 64'(segments), 64'h3FF_FFFF_FFFF);
    check("rst_ready_hold", 64'(ready), 64'(1));
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    mon = 1'b1;
    repeat (10) cycle();
    check("idle_seg", 64'(segments), 64'h3FF_FFFF_FFFF);
    check("idle_ready", 64'(ready), 64'(1));

    // Full decode, one digit per edge
    load_word(24'h00A3F0, 1'b0);
    check("dec_ready_e0", 64'(ready), 64'(0));
    low = 1;
    for (int k = 1; k <= D; k++) begin
      cycle();
      check("dec_digit", 64'(segments[7*(k-1) +: 7]), 64'(inv7(dec_exp[k-1])));
      if (!ready) low++;
    end
    check("dec_low_cycles", 64'(low), 64'(6));

    // Leading-zero blanking
    load_word(24'h000120, 1'b1);
    repeat (D) cycle();
    check("lz_120", 64'(segments),
          64'({inv7(7'h00), inv7(7'h00), inv7(7'h00), inv7(7'h06), inv7(7'h5B), inv7(7'h3F)}));
    load_word(24'h000000, 1'b1);
    repeat (D) cycle();
    check("lz_zero", 64'(segments),
          64'({inv7(7'h00), inv7(7'h00), inv7(7'h00), inv7(7'h00), inv7(7'h00), inv7(7'h3F)}));

    // Busy rejection, then held load taken on the final write edge
    load_word(24'h111111, 1'b0);
    repeat (2) cycle();
    value = 24'h222222;
    load  = 1'b1;
    repeat (4) cycle();
    check("busy_ones", 64'(segments), 64'({6{inv7(7'h06)}}));
    check("busy_rearm_ready", 64'(ready), 64'(0));
    load = 1'b0;
    repeat (D) cycle();
    check("busy_twos", 64'(segments), 64'({6{inv7(7'h5B)}}));
    check("busy_done_ready", 64'(ready), 64'(1));

    // Blink on digits 0-1
    blink_mask = 6'b000011;
    blink_en   = 1'b1;
    cnt0 = 0;
    bad  = 0;
    for (int k = 0; k < 2 * BD; k++) begin
      cycle();
      if (segments[6:0] == 7'h7F) cnt0++;
      if (segments[20:14] != inv7(7'h5B)) bad++;
    end
    check("blink_d0_blank_cycles", 64'(cnt0), 64'(BD));
    check("blink_d2_steady", 64'(bad), 64'(0));
    n = 0;
    while (segments[6:0] != 7'h7F && n < 2 * BD) begin
      cycle();
      n++;
    end
    check("blink_d0_blank", 64'(segments[6:0]), 64'(7'h7F));
    blink_en = 1'b0;
    #1;
    check("blink_off_same_cycle", 64'(segments[6:0]), 64'(inv7(7'h5B)));
    blink_en = 1'b1;
    #1;
    check("blink_on_same_cycle", 64'(segments[13:7]), 64'(7'h7F));
    blink_en = 1'b0;

    // Reset in the middle of an update
    load_word(24'h333333, 1'b0);
    repeat (3) cycle();
    reset_n = 1'b0;
    #1;
    check("midrst_seg", 64'(segments), 64'h3FF_FFFF_FFFF);
    check("midrst_ready", 64'(ready), 64'(1));
    #2;
    reset_n = 1'b1;
    load_word(24'h0BEEF5, 1'b1);
    repeat (D) cycle();
    check("midrst_reload", 64'(segments),
          64'({inv7(7'h00), inv7(7'h7C), inv7(7'h79), inv7(7'h79), inv7(7'h71), inv7(7'h6D)}));

    // Randomized traffic, checked each cycle by the model
    for (int k = 0; k < 400; k++) begin
      load       = ($urandom_range(0, 3) == 0);
      value      = ($urandom_range(0, 1) == 1) ? 24'($urandom)
                                               : 24'($urandom >> $urandom_range(12, 31));
      blank_lz   = 1'($urandom);
      blink_en   = 1'($urandom);
      blink_mask = 6'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
      cycle();
    end
    load = 1'b0;
    repeat (D + 1) cycle();

    mon = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
